// File: rtl/snake_grid.sv
`default_nettype none
// ============================================================================
// Module  : snake_grid
// Desc    : Segment-stream consumer for the snake mover. After each game
//           tick it requests segments one at a time, paints them into the
//           build half of a double-buffered occupancy bitmap, flags a
//           head-to-body collision and a segment-count overflow, and serves
//           the display half through a registered lookup port.
// Rev     : 1.0  initial release
// ============================================================================
module snake_grid #(
    parameter int                       H_LOGIC_WIDTH = 5,
    parameter int                       V_LOGIC_WIDTH = 5,
    parameter logic [H_LOGIC_WIDTH-1:0] H_LOGIC_MAX   = 5'd31,
    parameter logic [V_LOGIC_WIDTH-1:0] V_LOGIC_MAX   = 5'd23,
    parameter int                       MAX_SEG       = 200
) (
    input  logic                     clk,
    input  logic                     DLY_RST,
    input  logic                     vld,
    input  logic [H_LOGIC_WIDTH-1:0] x,
    input  logic [V_LOGIC_WIDTH-1:0] y,
    input  logic                     is_end,
    output logic                     pixel_done,
    input  logic [H_LOGIC_WIDTH-1:0] rd_x,
    input  logic [V_LOGIC_WIDTH-1:0] rd_y,
    output logic                     rd_occ,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     collision,
    output logic                     overflow
);

    // Bitmap geometry
    localparam int         COLS      = int'(H_LOGIC_MAX) + 1;
    localparam int         ROWS      = int'(V_LOGIC_MAX) + 1;
    localparam logic [7:0] SEG_LIMIT = 8'(MAX_SEG);

    // Frame-build sequencer states
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HEAD = 3'd1;
    localparam logic [2:0] S_REQ  = 3'd2;
    localparam logic [2:0] S_W1   = 3'd3;
    localparam logic [2:0] S_CAP  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]               state_q, state_d;
    logic [7:0]               seg_cnt_q, seg_cnt_d;
    logic [H_LOGIC_WIDTH-1:0] head_x_q, head_x_d;
    logic [V_LOGIC_WIDTH-1:0] head_y_q, head_y_d;
    logic                     coll_acc_q, coll_acc_d;
    logic                     ovf_acc_q, ovf_acc_d;
    logic                     disp_sel_q;
    logic                     collision_q;
    logic                     overflow_q;
    logic                     frame_done_q;
    logic                     rd_occ_q;

    // Two bitmap banks; disp_sel_q picks the one shown, the other is built
    logic [COLS-1:0]          bank0_q [ROWS];
    logic [COLS-1:0]          bank1_q [ROWS];

    logic                     clr_build;
    logic                     set_bit;
    logic                     swap;
    logic                     wr_en;
    logic [31:0]              x_ext, y_ext, rdx_ext, rdy_ext;
    logic [7:0]               seg_inc;
    logic [COLS-1:0]          col_mask;
    logic [COLS-1:0]          disp_row;
    logic                     rd_bit;

    assign x_ext    = 32'(x);
    assign y_ext    = 32'(y);
    assign rdx_ext  = 32'(rd_x);
    assign rdy_ext  = 32'(rd_y);
    assign seg_inc  = seg_cnt_q + 8'd1;
    assign col_mask = COLS'(1) << x;

    // Off-grid segments still count toward the frame but never touch the bitmap
    assign wr_en = set_bit
                 && (x_ext <= 32'(H_LOGIC_MAX))
                 && (y_ext <= 32'(V_LOGIC_MAX));

    // Next-state logic; a tick restarts the build from any state
    always_comb begin
        state_d    = state_q;
        seg_cnt_d  = seg_cnt_q;
        head_x_d   = head_x_q;
        head_y_d   = head_y_q;
        coll_acc_d = coll_acc_q;
        ovf_acc_d  = ovf_acc_q;
        clr_build  = 1'b0;
        set_bit    = 1'b0;
        swap       = 1'b0;
        if (vld) begin
            state_d    = S_HEAD;
            clr_build  = 1'b1;
            seg_cnt_d  = 8'd0;
            coll_acc_d = 1'b0;
            ovf_acc_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_HEAD: begin
                    head_x_d  = x;
                    head_y_d  = y;
                    set_bit   = 1'b1;
                    seg_cnt_d = 8'd1;
                    state_d   = S_REQ;
                end
                S_REQ: begin
                    state_d = S_W1;
                end
                S_W1: begin
                    state_d = S_CAP;
                end
                S_CAP: begin
                    set_bit   = 1'b1;
                    seg_cnt_d = seg_inc;
                    if ((x == head_x_q) && (y == head_y_q)) begin
                        coll_acc_d = 1'b1;
                    end
                    if (is_end) begin
                        state_d = S_DONE;
                    end else if (seg_inc == SEG_LIMIT) begin
                        ovf_acc_d = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_DONE: begin
                    swap    = 1'b1;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Sequencer, status flags and bank-select registers
    always_ff @(posedge clk or negedge DLY_RST) begin
        if (!DLY_RST) begin
            state_q      <= S_IDLE;
            seg_cnt_q    <= 8'd0;
            head_x_q     <= '0;
            head_y_q     <= '0;
            coll_acc_q   <= 1'b0;
            ovf_acc_q    <= 1'b0;
            disp_sel_q   <= 1'b0;
            collision_q  <= 1'b0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            seg_cnt_q    <= seg_cnt_d;
            head_x_q     <= head_x_d;
            head_y_q     <= head_y_d;
            coll_acc_q   <= coll_acc_d;
            ovf_acc_q    <= ovf_acc_d;
            frame_done_q <= swap;
            if (swap) begin
                disp_sel_q  <= ~disp_sel_q;
                collision_q <= coll_acc_q;
                overflow_q  <= ovf_acc_q;
            end
        end
    end

    // Bitmap banks: only the non-displayed bank is ever cleared or painted
    always_ff @(posedge clk or negedge DLY_RST) begin
        if (!DLY_RST) begin
            for (int r = 0; r < ROWS; r++) begin
                bank0_q[r] <= '0;
                bank1_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                if (disp_sel_q) begin
                    if (clr_build) begin
                        bank0_q[r] <= '0;
                    end else if (wr_en && (y_ext == $unsigned(r))) begin
                        bank0_q[r] <= bank0_q[r] | col_mask;
                    end
                end else begin
                    if (clr_build) begin
                        bank1_q[r] <= '0;
                    end else if (wr_en && (y_ext == $unsigned(r))) begin
                        bank1_q[r] <= bank1_q[r] | col_mask;
                    end
                end
            end
        end
    end

    // Display-bank row select; rows past the grid read as empty
    always_comb begin
        disp_row = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (rdy_ext == $unsigned(r)) begin
                disp_row = disp_sel_q ? bank1_q[r] : bank0_q[r];
            end
        end
    end

    assign rd_bit = (rdx_ext <= 32'(H_LOGIC_MAX)) ? disp_row[rd_x] : 1'b0;

    // Registered lookup port
    always_ff @(posedge clk or negedge DLY_RST) begin
        if (!DLY_RST) begin
            rd_occ_q <= 1'b0;
        end else begin
            rd_occ_q <= rd_bit;
        end
    end

    // busy also spans the frame_done cycle so the build window is contiguous
    assign pixel_done = (state_q == S_REQ);
    assign busy       = (state_q != S_IDLE) | frame_done_q;
    assign frame_done = frame_done_q;
    assign collision  = collision_q;
    assign overflow   = overflow_q;
    assign rd_occ     = rd_occ_q;

endmodule
`default_nettype wire
